// File: rtl/cavlc_level_pack_pkg.sv
// Shared constants and payload types for the CAVLC level bit packer.
//   CAVLC_OUT_W       output word width
//   CAVLC_ACC_W       accumulator depth in bits
//   CAVLC_MAX_PREFIX  largest encodable level prefix
//   CAVLC_BEAT_MAXLEN largest single-beat bit count (3 signs + 2 x 31)
package cavlc_level_pack_pkg;

  localparam int unsigned CAVLC_OUT_W       = 32;
  localparam int unsigned CAVLC_ACC_W       = 128;
  localparam int unsigned CAVLC_MAX_PREFIX  = 15;
  localparam int unsigned CAVLC_BEAT_MAXLEN = 65;

  localparam int unsigned CW_W       = 31;  // left-aligned codeword width
  localparam int unsigned CW_LEN_W   = 5;   // codeword length width
  localparam int unsigned BEAT_LEN_W = 7;   // beat length width (0..65)
  localparam int unsigned FILL_W     = 8;   // accumulator fill width (0..128)
  localparam int unsigned OUT_BITS_W = 6;   // out_bits width (0..32)

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // One packed beat: bits left-aligned in vec, len of them valid.
  typedef struct packed {
    logic [CAVLC_BEAT_MAXLEN-1:0] vec;
    logic [BEAT_LEN_W-1:0]        len;
  } beat_t;

endpackage

// File: rtl/cavlc_cw_build.sv
// Combinational level codeword former: prefix zeros, a one, then the
// suffix MSB-first, left-aligned in a 31-bit field.
//   en_i            level present
//   prefix_i        leading-zero count (values above 15 are clamped)
//   suffixlength_i  suffix bit count
//   suffix_i        suffix value, LSB-aligned
//   cw_o            codeword, first bit at cw_o[30]
//   len_o           codeword length (0 when absent)
//   clamp_o         prefix was out of range for a present level
module cavlc_cw_build
  import cavlc_level_pack_pkg::*;
(
  input  logic                en_i,
  input  logic [4:0]          prefix_i,
  input  logic [3:0]          suffixlength_i,
  input  logic [14:0]         suffix_i,
  output logic [CW_W-1:0]     cw_o,
  output logic [CW_LEN_W-1:0] len_o,
  output logic                clamp_o
);

  logic                over_c;
  logic [3:0]          prefix_c;
  logic [31:0]         mask_c;
  logic [31:0]         val_c;
  logic [CW_LEN_W-1:0] len_c;
  logic [CW_W-1:0]     shifted_c;

  // Right-aligned value is the marker one followed by the suffix; the
  // prefix zeros appear once it is shifted up to the top of the field.
  always_comb begin
    over_c    = prefix_i > 5'(CAVLC_MAX_PREFIX);
    prefix_c  = over_c ? 4'(CAVLC_MAX_PREFIX) : prefix_i[3:0];
    mask_c    = (32'd1 << suffixlength_i) - 32'd1;
    val_c     = (32'd1 << suffixlength_i) | (32'(suffix_i) & mask_c);
    len_c     = 5'(prefix_c) + 5'd1 + 5'(suffixlength_i);
    shifted_c = 31'(val_c << (5'd31 - len_c));
    cw_o      = en_i ? shifted_c : '0;
    len_o     = en_i ? len_c : '0;
    clamp_o   = en_i && over_c;
  end

endmodule

// File: rtl/cavlc_level_pack.sv
// CAVLC level bit packer: forms sign + level codewords per beat, packs
// them MSB-first into a 128-bit accumulator and emits 32-bit words.
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input beat handshake
//   sign_bits, sign_len        trailing-one signs, [2] first
//   enable                     level presence, [0] level0, [1] level1
//   prefix*/suffixlength*/suffix*  level fields
//   flush                      drain request incl. partial word
//   out_valid/out_ready        output word handshake
//   out_data, out_bits         packed word (MSB oldest) and valid bit count
//   out_last                   final partial word of a flush
//   flush_done                 one-cycle flush completion pulse
//   err                        sticky prefix-overflow flag
module cavlc_level_pack
  import cavlc_level_pack_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            sign_bits,
  input  logic [1:0]            sign_len,
  input  logic [1:0]            enable,
  input  logic [4:0]            prefix0,
  input  logic [4:0]            prefix1,
  input  logic [3:0]            suffixlength0,
  input  logic [3:0]            suffixlength1,
  input  logic [14:0]           suffix0,
  input  logic [14:0]           suffix1,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CAVLC_OUT_W-1:0] out_data,
  output logic [OUT_BITS_W-1:0] out_bits,
  output logic                  out_last,
  output logic                  flush_done,
  output logic                  err
);

  logic [0:0]             state_q, state_d;
  beat_t                  s1_q, s1_d;
  logic [CAVLC_ACC_W-1:0] acc_q, acc_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   out_valid_q, out_valid_d;
  logic [CAVLC_OUT_W-1:0] out_data_q, out_data_d;
  logic [OUT_BITS_W-1:0]  out_bits_q, out_bits_d;
  logic                   out_last_q, out_last_d;
  logic                   flush_done_q, flush_done_d;
  logic                   err_q, err_d;

  logic [CW_W-1:0]        cw0, cw1;
  logic [CW_LEN_W-1:0]    len0, len1;
  logic                   clamp0, clamp1;
  beat_t                  beat_c;
  logic                   accept_c;
  logic                   pop_c;
  logic [FILL_W-1:0]      fill_pop_c;
  logic                   full_c;
  logic                   part_c;

  cavlc_cw_build u_cw0 (
    .en_i           (enable[0]),
    .prefix_i       (prefix0),
    .suffixlength_i (suffixlength0),
    .suffix_i       (suffix0),
    .cw_o           (cw0),
    .len_o          (len0),
    .clamp_o        (clamp0)
  );

  cavlc_cw_build u_cw1 (
    .en_i           (enable[1]),
    .prefix_i       (prefix1),
    .suffixlength_i (suffixlength1),
    .suffix_i       (suffix1),
    .cw_o           (cw1),
    .len_o          (len1),
    .clamp_o        (clamp1)
  );

  // Headroom rule: whatever is in S1 plus one worst-case beat must fit.
  assign in_ready = (state_q == ST_RUN) &&
                    ((9'(fill_q) + 9'(s1_q.len)) <= 9'd63);
  assign accept_c = in_valid && in_ready;
  assign pop_c    = out_valid_q && out_ready;

  // Beat concatenation: signs, then level0, then level1, left-aligned.
  always_comb begin
    beat_c.vec = ({sign_bits, 62'b0} & ~({CAVLC_BEAT_MAXLEN{1'b1}} >> sign_len))
               | ({cw0, 34'b0} >> sign_len)
               | ({cw1, 34'b0} >> (7'(sign_len) + 7'(len0)));
    beat_c.len = 7'(sign_len) + 7'(len0) + 7'(len1);
  end

  // Datapath next state: pop first, then S1 lands just below the new fill.
  always_comb begin
    s1_d       = accept_c ? beat_c : '0;
    fill_pop_c = fill_q - (pop_c ? 8'(out_bits_q) : 8'd0);
    acc_d      = (pop_c ? (acc_q << CAVLC_OUT_W) : acc_q)
               | ({s1_q.vec, 63'b0} >> fill_pop_c);
    fill_d     = fill_pop_c + 8'(s1_q.len);
    err_d      = err_q || (accept_c && (clamp0 || clamp1));
  end

  // Control FSM: RUN accepts beats, FLUSH drains to an empty accumulator.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pop_c && out_last_q) begin
          flush_done_d = 1'b1;
          state_d      = ST_RUN;
        end else if ((s1_q.len == '0) && (fill_q == '0)) begin
          flush_done_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output word is derived from next-state so registered outputs track
  // the accumulator without an extra cycle of lag.
  always_comb begin
    full_c      = fill_d >= 8'(CAVLC_OUT_W);
    part_c      = (state_d == ST_FLUSH) && (s1_d.len == '0) &&
                  (fill_d != '0) && !full_c;
    out_valid_d = full_c || part_c;
    out_last_d  = part_c;
    out_data_d  = out_valid_d ? acc_d[CAVLC_ACC_W-1 -: CAVLC_OUT_W] : '0;
    out_bits_d  = '0;
    if (full_c)      out_bits_d = 6'(CAVLC_OUT_W);
    else if (part_c) out_bits_d = 6'(fill_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      s1_q         <= '0;
      acc_q        <= '0;
      fill_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_bits_q   <= '0;
      out_last_q   <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_bits_q   <= out_bits_d;
      out_last_q   <= out_last_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_bits   = out_bits_q;
  assign out_last   = out_last_q;
  assign flush_done = flush_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cavlc_level_pack.sv
// Scoreboard bench for cavlc_level_pack: a bit-level model builds the
// expected word stream as beats and flushes are accepted.
module tb_cavlc_level_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  sign_bits = '0;
  logic [1:0]  sign_len = '0;
  logic [1:0]  enable = '0;
  logic [4:0]  prefix0 = '0, prefix1 = '0;
  logic [3:0]  suffixlength0 = '0, suffixlength1 = '0;
  logic [14:0] suffix0 = '0, suffix1 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [5:0]  out_bits;
  logic        out_last;
  logic        flush_done;
  logic        err;

  always #5 clk = ~clk;

  cavlc_level_pack dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_bits(sign_bits), .sign_len(sign_len), .enable(enable),
    .prefix0(prefix0), .prefix1(prefix1),
    .suffixlength0(suffixlength0), .suffixlength1(suffixlength1),
    .suffix0(suffix0), .suffix1(suffix1),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bits(out_bits), .out_last(out_last),
    .flush_done(flush_done), .err(err)
  );

  typedef struct {
    logic [31:0] d;
    logic [5:0]  b;
    logic        l;
  } exp_t;

  exp_t eq[$];
  bit   mq[$];
  int   fd_pending = 0;
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  exp_t        mon_e;
  bit          stall_q = 1'b0;
  logic [31:0] held_d;
  logic [5:0]  held_b;
  logic        held_l;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_level(input logic en, input logic [4:0] p,
                                      input logic [3:0] sl, input logic [14:0] s);
    int pc;
    if (!en) return;
    pc = (p > 5'd15) ? 15 : int'(p);
    for (int i = 0; i < pc; i++) mq.push_back(1'b0);
    mq.push_back(1'b1);
    for (int i = int'(sl) - 1; i >= 0; i--) mq.push_back(s[i]);
  endfunction

  function automatic void model_words();
    exp_t e;
    while (mq.size() >= 32) begin
      e.d = '0;
      for (int i = 0; i < 32; i++) e.d[31-i] = mq.pop_front();
      e.b = 6'd32;
      e.l = 1'b0;
      eq.push_back(e);
    end
  endfunction

  function automatic void model_flush();
    exp_t e;
    int   n;
    n = mq.size();
    if (n > 0) begin
      e.d = '0;
      for (int i = 0; i < n; i++) e.d[31-i] = mq.pop_front();
      e.b = 6'(n);
      e.l = 1'b1;
      eq.push_back(e);
    end
    fd_pending++;
  endfunction

  // Output ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor on the falling edge: handshakes seen here complete at the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data",  64'(out_data),  64'(held_d));
        chk("stall_bits",  64'(out_bits),  64'(held_b));
        chk("stall_last",  64'(out_last),  64'(held_l));
      end
      if (out_valid && out_ready) begin
        if (eq.size() == 0) chk("extra_word", 64'(out_data), 64'hDEAD_0000_0000);
        else begin
          mon_e = eq.pop_front();
          chk("word_data", 64'(out_data), 64'(mon_e.d));
          chk("word_bits", 64'(out_bits), 64'(mon_e.b));
          chk("word_last", 64'(out_last), 64'(mon_e.l));
        end
      end
      stall_q = out_valid && !out_ready;
      held_d  = out_data;
      held_b  = out_bits;
      held_l  = out_last;
      if (stall_q) chk("fill_max", 64'(dut.fill_q <= 8'd128), 64'd1);
      if (flush_done) begin
        chk("flush_done_expected", 64'(fd_pending > 0), 64'd1);
        chk("flush_done_after_last", 64'(eq.size()), 64'd0);
        if (fd_pending > 0) fd_pending--;
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < int'(sign_len); i++) mq.push_back(sign_bits[2-i]);
        model_level(enable[0], prefix0, suffixlength0, suffix0);
        model_level(enable[1], prefix1, suffixlength1, suffix1);
        model_words();
      end
      if (flush) model_flush();
    end else begin
      stall_q = 1'b0;
    end
  end

  // All drive tasks start and end just after a rising edge.
  task automatic send(input logic [2:0] sb, input logic [1:0] sl, input logic [1:0] en,
                      input logic [4:0] p0, input logic [3:0] l0, input logic [14:0] s0,
                      input logic [4:0] p1, input logic [3:0] l1, input logic [14:0] s1);
    bit ok;
    int n;
    sign_bits = sb; sign_len = sl; enable = en;
    prefix0 = p0; suffixlength0 = l0; suffix0 = s0;
    prefix1 = p1; suffixlength1 = l1; suffix1 = s1;
    in_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((eq.size() != 0 || fd_pending != 0) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) chk("drain_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  r_sb;
    logic [1:0]  r_sl, r_en;
    logic [4:0]  r_p0, r_p1;
    logic [3:0]  r_l0, r_l1;
    logic [14:0] r_s0, r_s1;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_out_data",   64'(out_data),   64'd0);
    chk("rst_out_bits",   64'(out_bits),   64'd0);
    chk("rst_out_last",   64'(out_last),   64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_err",        64'(err),        64'd0);
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    @(posedge clk);
    #1;

    // Single beat then flush: 7-bit partial word 8E000000.
    send(3'b100, 2'd2, 2'b11, 5'd2, 4'd1, 15'd1, 5'd0, 4'd0, 15'd0);
    do_flush();
    drain();

    // Worst-case 65-bit beats.
    send(3'b111, 2'd3, 2'b11, 5'd15, 4'd15, 15'h7FFF, 5'd15, 4'd15, 15'h7FFF);
    @(negedge clk);
    chk("in_ready_drop", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      send(3'b111, 2'd3, 2'b11, 5'd15, 4'd15, 15'h7FFF, 5'd15, 4'd15, 15'h7FFF);
    do_flush();
    drain();

    // Backpressure: output stalled for 20 cycles while beats are offered.
    rdy_mode = 0;
    fork
      begin
        repeat (20) @(posedge clk);
        rdy_mode = 1;
      end
    join_none
    for (int i = 0; i < 6; i++)
      send(3'(i), 2'(i % 4), 2'b11, 5'(i + 3), 4'(i * 2), 15'(16'h5A5A >> i),
           5'(i), 4'(15 - i), 15'(16'h3C3C << i));
    do_flush();
    drain();

    // Exact multiple of 32: no last word, a single flush_done.
    send(3'b000, 2'd0, 2'b11, 5'd15, 4'd15, 15'h1234, 5'd0, 4'd0, 15'd0);
    send(3'b000, 2'd0, 2'b11, 5'd15, 4'd15, 15'h4321, 5'd0, 4'd0, 15'd0);
    do_flush();
    drain();

    // Prefix clamp and sticky error.
    send(3'b000, 2'd0, 2'b01, 5'd20, 4'd2, 15'd3, 5'd0, 4'd0, 15'd0);
    do_flush();
    drain();
    chk("err_set", 64'(err), 64'd1);
    send(3'b010, 2'd1, 2'b01, 5'd1, 4'd3, 15'd5, 5'd0, 4'd0, 15'd0);
    do_flush();
    drain();
    chk("err_sticky", 64'(err), 64'd1);

    // Random beats with random output backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      r_sb = 3'($urandom); r_sl = 2'($urandom); r_en = 2'($urandom);
      r_p0 = 5'($urandom_range(0, 15)); r_l0 = 4'($urandom); r_s0 = 15'($urandom);
      r_p1 = 5'($urandom_range(0, 15)); r_l1 = 4'($urandom); r_s1 = 15'($urandom);
      send(r_sb, r_sl, r_en, r_p0, r_l0, r_s0, r_p1, r_l1, r_s1);
      if ($urandom_range(0, 7) == 0) begin
        do_flush();
        drain();
      end
    end
    do_flush();
    drain();

    // Reset with 40 bits buffered.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(3'b111, 2'd3, 2'b11, 5'd15, 4'd15, 15'h7FFF, 5'd5, 4'd0, 15'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("fill_before_reset", 64'(dut.fill_q), 64'd40);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid",  64'(out_valid),  64'd0);
    chk("mid_rst_out_data",   64'(out_data),   64'd0);
    chk("mid_rst_out_bits",   64'(out_bits),   64'd0);
    chk("mid_rst_out_last",   64'(out_last),   64'd0);
    chk("mid_rst_flush_done", 64'(flush_done), 64'd0);
    chk("mid_rst_err",        64'(err),        64'd0);
    eq.delete();
    mq.delete();
    fd_pending = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    do_flush();
    drain();

    chk("end_words_left", 64'(eq.size()), 64'd0);
    chk("end_flush_pending", 64'(fd_pending), 64'd0);
    chk("end_bits_left", 64'(mq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
